// File: rtl/program_memory_loader.sv
// Unified 4096x16 program/data memory with a byte-serial boot loader that stalls the CPU while loading.
// Optional trailer checksum verification is enabled by defining LOADER_CHECKSUM_EN.
module program_memory_loader #(
  parameter int ADDR_W    = 12,
  parameter int DEPTH     = 4096,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  input  logic              mem_load,
  output logic [15:0]       rdata,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_words,
  input  logic [7:0]        load_byte,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
`ifdef LOADER_CHECKSUM_EN
    S_CHK_HI,
    S_CHK_LO,
`endif
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] MAX_WORDS = (ADDR_W+1)'(DEPTH);

  logic [15:0]     mem [DEPTH];
  state_t          state_q, state_d;
  logic [ADDR_W:0] count_q, count_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [7:0]      hi_q, hi_d;
  logic [15:0]     rdata_q;
  logic            ld_we;
  logic [15:0]     ld_wdata;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0]     sum_q, sum_d;
  logic            err_q, err_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    ld_we    = 1'b0;
    ld_wdata = {hi_q, load_byte};
`ifdef LOADER_CHECKSUM_EN
    sum_d    = sum_q;
    err_d    = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (load_start && (load_words != '0) && (load_words <= MAX_WORDS)) begin
          count_d = load_words;
          cnt_d   = '0;
          state_d = S_HI;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      S_HI: begin
        if (load_valid) begin
          hi_d    = load_byte;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (load_valid) begin
          ld_we = 1'b1;
          cnt_d = cnt_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum_d = sum_q + ld_wdata;
          state_d = (cnt_q == count_q - 1'b1) ? S_CHK_HI : S_HI;
`else
          state_d = (cnt_q == count_q - 1'b1) ? S_DONE : S_HI;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK_HI: begin
        if (load_valid) begin
          hi_d    = load_byte;
          state_d = S_CHK_LO;
        end
      end
      S_CHK_LO: begin
        if (load_valid) begin
          if (ld_wdata != sum_q) err_d = 1'b1;
          state_d = S_DONE;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cpu_hold   = (state_q != S_IDLE);
  assign load_done  = (state_q == S_DONE);
`ifdef LOADER_CHECKSUM_EN
  assign load_ready = (state_q == S_HI) || (state_q == S_LO) ||
                      (state_q == S_CHK_HI) || (state_q == S_CHK_LO);
  assign load_err   = err_q;
`else
  assign load_ready = (state_q == S_HI) || (state_q == S_LO);
  assign load_err   = 1'b0;
`endif

  // Loader and CPU never write together: CPU stores are blocked while cpu_hold is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (ld_we) mem[cnt_q[ADDR_W-1:0]] <= ld_wdata;
      else if (mem_load && !cpu_hold) mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_program_memory_loader.sv
// Self-checking bench for program_memory_loader: CPU access, boot loads with gaps, reset abort, checksum.
module tb_program_memory_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] addr;
  logic [15:0] wdata;
  logic        mem_load;
  logic [15:0] rdata;
  logic        load_start;
  logic [12:0] load_words;
  logic [7:0]  load_byte;
  logic        load_valid;
  logic        load_ready;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] ref_mem [4096];

  program_memory_loader dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .mem_load(mem_load), .rdata(rdata),
    .load_start(load_start), .load_words(load_words), .load_byte(load_byte),
    .load_valid(load_valid), .load_ready(load_ready), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] sum16(input logic [15:0] w[$]);
    logic [31:0] s = 0;
    foreach (w[i]) s = s + {16'h0, w[i]};
    return s[15:0];
  endfunction

  task automatic cpu_write(input logic [11:0] a, input logic [15:0] d);
    addr = a; wdata = d; mem_load = 1'b1;
    tick;
    mem_load = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic cpu_read(input logic [11:0] a, output logic [15:0] d);
    addr = a; mem_load = 1'b0;
    tick;
    d = rdata;
  endtask

  // Drives one complete load; reports what was observed so callers can compare against the model.
  task automatic run_load(input int n, input logic [15:0] w[$], input logic [15:0] trailer,
                          input bit gaps, input bit cpu_poke, input bit stray,
                          output bit timeout, output int hold_low, output int early_done,
                          output logic d0, output logic h0, output logic d1, output logic h1,
                          output logic err_start);
    logic [7:0] bytes[$];
    int idx = 0;
    int budget = 0;
    bit xfer;
    foreach (w[i]) begin bytes.push_back(w[i][15:8]); bytes.push_back(w[i][7:0]); end
`ifdef LOADER_CHECKSUM_EN
    bytes.push_back(trailer[15:8]); bytes.push_back(trailer[7:0]);
`endif
    hold_low = 0; early_done = 0;
    load_words = 13'(n); load_start = 1'b1;
    tick;
    load_start = 1'b0;
    err_start = load_err;
    while (idx < bytes.size() && budget < 30000) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        load_valid = 1'b0;
        load_byte  = 8'($urandom);
      end else begin
        load_valid = 1'b1;
        load_byte  = bytes[idx];
      end
      if (cpu_poke) begin mem_load = 1'b1; addr = 12'h001; wdata = 16'hFFFF; end
      if (stray) begin load_start = 1'($urandom_range(0, 1)); load_words = 13'd1; end
      if (!cpu_hold) hold_low++;
      if (load_done) early_done++;
      xfer = load_valid && load_ready;
      tick;
      if (xfer) idx++;
      budget++;
    end
    load_valid = 1'b0; mem_load = 1'b0; load_start = 1'b0;
    timeout = (idx < bytes.size());
    d0 = load_done; h0 = cpu_hold;
    tick;
    d1 = load_done; h1 = cpu_hold;
    if (!timeout) for (int i = 0; i < n; i++) ref_mem[i] = w[i];
  endtask

  task automatic test_reset;
    logic [15:0] d;
    rst = 1'b1; addr = 12'h005; wdata = 16'h0; mem_load = 1'b0;
    load_start = 1'b0; load_words = 13'd0; load_byte = 8'h0; load_valid = 1'b0;
    tick; tick;
    n_cmp++; if (rdata !== 16'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0000", rdata); end
    n_cmp++; if ({load_ready, cpu_hold, load_done, load_err} !== 4'b0) begin
      n_fail++; $display("FAIL reset_outputs got=%b exp=0000", {load_ready, cpu_hold, load_done, load_err}); end
    rst = 1'b0;
    cpu_write(12'h005, 16'hBEEF);
    cpu_read(12'h005, d);
    n_cmp++; if (d !== 16'hBEEF) begin n_fail++; $display("FAIL reset_read5 got=%h exp=beef", d); end
  endtask

  task automatic test_cpu_rw;
    logic [15:0] d;
    cpu_write(12'h123, 16'h1111);
    addr = 12'h123; wdata = 16'hA55A; mem_load = 1'b1;
    tick;
    mem_load = 1'b0; ref_mem[12'h123] = 16'hA55A;
    n_cmp++; if (rdata !== 16'h1111) begin n_fail++; $display("FAIL rbw_old got=%h exp=1111", rdata); end
    tick;
    n_cmp++; if (rdata !== 16'hA55A) begin n_fail++; $display("FAIL cpu_write got=%h exp=a55a", rdata); end
    for (int i = 0; i < 8; i++) begin
      logic [11:0] a = 12'($urandom_range(16, 4095));
      cpu_write(a, 16'($urandom));
      cpu_read(a, d);
      n_cmp++; if (d !== ref_mem[a]) begin n_fail++; $display("FAIL cpu_rand a=%h got=%h exp=%h", a, d, ref_mem[a]); end
    end
  endtask

  task automatic check_load(input string nm, input int n, input logic [15:0] w[$], input bit gaps,
                            input bit poke, input bit stray);
    bit to; int hl, ed; logic d0, h0, d1, h1, es; logic [15:0] d;
    run_load(n, w, sum16(w), gaps, poke, stray, to, hl, ed, d0, h0, d1, h1, es);
    n_cmp++; if (to) begin n_fail++; $display("FAIL %s_timeout got=stalled exp=all bytes accepted", nm); end
    n_cmp++; if (hl != 0) begin n_fail++; $display("FAIL %s_hold got=%0d low cycles exp=0", nm, hl); end
    n_cmp++; if (ed != 0) begin n_fail++; $display("FAIL %s_early_done got=%0d exp=0", nm, ed); end
    n_cmp++; if ({d0, h0, d1, h1} !== 4'b1100) begin
      n_fail++; $display("FAIL %s_done_pulse got=%b exp=1100", nm, {d0, h0, d1, h1}); end
    n_cmp++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL %s_err got=%b exp=0", nm, load_err); end
    for (int i = 0; i < n; i++) begin
      cpu_read(12'(i), d);
      n_cmp++; if (d !== ref_mem[i]) begin
        n_fail++; $display("FAIL %s_mem a=%0d got=%h exp=%h", nm, i, d, ref_mem[i]); end
    end
  endtask

  task automatic test_load;
    logic [15:0] w[$] = '{16'h1234, 16'h5678, 16'h9ABC};
    check_load("load3", 3, w, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure;
    logic [15:0] w[$] = '{16'h1234, 16'h5678, 16'h9ABC};
    cpu_write(12'h000, 16'h0); cpu_write(12'h001, 16'h0); cpu_write(12'h002, 16'h0);
    check_load("gaps", 3, w, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_load;
    logic [7:0] b[4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    logic [15:0] d;
    cpu_write(12'h000, 16'h0000);
    cpu_write(12'h001, 16'h0BAD);
    load_words = 13'd3; load_start = 1'b1;
    tick;
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin load_valid = 1'b1; load_byte = b[i]; tick; end
    load_byte = b[3]; rst = 1'b1;
    tick;
    rst = 1'b0; load_valid = 1'b0;
    ref_mem[0] = 16'h1234;
    n_cmp++; if ({cpu_hold, load_ready} !== 2'b00) begin
      n_fail++; $display("FAIL abort_state got=%b exp=00", {cpu_hold, load_ready}); end
    cpu_read(12'h000, d);
    n_cmp++; if (d !== 16'h1234) begin n_fail++; $display("FAIL abort_mem0 got=%h exp=1234", d); end
    cpu_read(12'h001, d);
    n_cmp++; if (d !== 16'h0BAD) begin n_fail++; $display("FAIL abort_mem1 got=%h exp=0bad", d); end
  endtask

  task automatic test_illegal_start;
    logic [12:0] bad[2] = '{13'd0, 13'd4097};
    for (int k = 0; k < 2; k++) begin
      load_words = bad[k]; load_start = 1'b1;
      tick;
      load_start = 1'b0;
      n_cmp++; if ({cpu_hold, load_ready} !== 2'b00) begin
        n_fail++; $display("FAIL illegal_start words=%0d got=%b exp=00", bad[k], {cpu_hold, load_ready}); end
      tick;
      n_cmp++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL illegal_hold words=%0d got=%b exp=0", bad[k], cpu_hold); end
    end
  endtask

  task automatic test_random_loads;
    for (int r = 0; r < 4; r++) begin
      logic [15:0] w[$];
      int n = $urandom_range(1, 9);
      for (int i = 0; i < n; i++) w.push_back(16'($urandom));
      check_load("rand", n, w, 1'b1, 1'b1, 1'b1);
    end
  endtask

  task automatic test_full_load;
    logic [15:0] w[$];
    for (int i = 0; i < 4096; i++) w.push_back(16'($urandom));
    check_load("full", 4096, w, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_checksum;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0] w[$] = '{16'h0001, 16'hFFFF};
    bit to; int hl, ed; logic d0, h0, d1, h1, es;
    run_load(2, w, 16'h0000, 1'b0, 1'b0, 1'b0, to, hl, ed, d0, h0, d1, h1, es);
    n_cmp++; if (to || load_err !== 1'b0) begin
      n_fail++; $display("FAIL chk_good got=%b timeout=%0d exp=0", load_err, to); end
    run_load(2, w, 16'h0001, 1'b1, 1'b0, 1'b0, to, hl, ed, d0, h0, d1, h1, es);
    n_cmp++; if (to || load_err !== 1'b1) begin
      n_fail++; $display("FAIL chk_bad got=%b timeout=%0d exp=1", load_err, to); end
    tick;
    n_cmp++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL chk_sticky got=%b exp=1", load_err); end
    run_load(2, w, 16'h0000, 1'b0, 1'b0, 1'b0, to, hl, ed, d0, h0, d1, h1, es);
    n_cmp++; if (es !== 1'b0) begin n_fail++; $display("FAIL chk_clear got=%b exp=0", es); end
    n_cmp++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL chk_after got=%b exp=0", load_err); end
`else
    n_cmp++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL err_tied got=%b exp=0", load_err); end
`endif
  endtask

  initial begin
    test_reset;
    test_cpu_rw;
    test_load;
    test_backpressure;
    test_reset_mid_load;
    test_illegal_start;
    test_random_loads;
    test_full_load;
    test_checksum;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
